// File: rtl/gpio_port_if.sv
// gpio_port_if: register-bus interface for gpio_port.
//   sel   - access strobe, one cycle per access
//   we    - 1 = write, 0 = read (qualified by sel)
//   addr  - register select: 0 IN, 1 OUT, 2 EDGE, 3 IRQ_EN
//   wdata - write data
//   rdata - registered read data
interface gpio_port_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_port.sv
// gpio_port: debounced GPIO input port with rising-edge capture, output
// register and a level interrupt, accessed over a simple register bus.
//   clk     - clock, all state changes on its rising edge
//   rst     - synchronous active-high reset
//   gpio_i  - asynchronous input pins (IN_W)
//   gpio_o  - output pins, driven from the OUT register (OUT_W)
//   bus     - gpio_port_if.slave: sel/we/addr/wdata in, rdata out
//   irq     - registered OR(EDGE & IRQ_EN)
// Build option: define GPIO_DEBOUNCE_EN to build the per-bit debounce
// counters; when undefined the stable vector is the synchroniser output.
module gpio_port #(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_W      = 9,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  gpio_i,
  output logic [OUT_W-1:0] gpio_o,
  gpio_port_if.slave       bus,
  output logic             irq
);

  localparam int unsigned DATA_W = 32;

  // Parameter range guard, evaluated at elaboration.
  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535 || IN_W > DATA_W || OUT_W > DATA_W) begin : g_param_chk
    $error("gpio_port: parameter out of range");
  end

  logic [IN_W-1:0]  sync1;
  logic [IN_W-1:0]  stable;
  logic [IN_W-1:0]  stable_nxt_c;
  logic [IN_W-1:0]  edge_q;
  logic [IN_W-1:0]  edge_nxt_c;
  logic [IN_W-1:0]  edge_clr_c;
  logic [IN_W-1:0]  irq_en;
  logic [OUT_W-1:0] out_q;
  logic [DATA_W-1:0] rd_mux_c;
  logic             wr_c;
  logic             rd_c;

  // Upper wdata bits are intentionally ignored.
  logic unused_wdata_c;
  assign unused_wdata_c = ^bus.wdata;

  assign wr_c   = bus.sel & bus.we;
  assign rd_c   = bus.sel & ~bus.we;
  assign gpio_o = out_q;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [IN_W-1:0]  sync2;
  logic [CNT_W-1:0] cnt     [IN_W];
  logic [CNT_W-1:0] cnt_nxt_c [IN_W];

  // Per-bit debounce: count while sync2 disagrees with stable, accept at CNT_LAST.
  always_comb begin
    stable_nxt_c = stable;
    for (int i = 0; i < int'(IN_W); i++) begin
      cnt_nxt_c[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt_c[i] = sync2[i];
        end else begin
          cnt_nxt_c[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Second synchroniser stage and debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync2 <= '0;
      for (int i = 0; i < int'(IN_W); i++) cnt[i] <= '0;
    end else begin
      sync2 <= sync1;
      for (int i = 0; i < int'(IN_W); i++) cnt[i] <= cnt_nxt_c[i];
    end
  end
`else
  // No debounce: the stable register itself is the second synchroniser flop.
  assign stable_nxt_c = sync1;
`endif

  // W1C clear from the bus; a simultaneous rising edge wins.
  assign edge_clr_c = (wr_c && bus.addr == 2'd2) ? bus.wdata[IN_W-1:0] : '0;
  assign edge_nxt_c = (edge_q & ~edge_clr_c) | (stable_nxt_c & ~stable);

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux_c = '0;
    case (bus.addr)
      2'd0:    rd_mux_c = DATA_W'(stable);
      2'd1:    rd_mux_c = DATA_W'(out_q);
      2'd2:    rd_mux_c = DATA_W'(edge_q);
      default: rd_mux_c = DATA_W'(irq_en);
    endcase
  end

  // Register file, first synchroniser stage, stable vector and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      stable    <= '0;
      edge_q    <= '0;
      irq_en    <= '0;
      out_q     <= '0;
      bus.rdata <= '0;
      irq       <= 1'b0;
    end else begin
      sync1  <= gpio_i;
      stable <= stable_nxt_c;
      edge_q <= edge_nxt_c;
      irq    <= |(edge_q & irq_en);
      if (wr_c && bus.addr == 2'd1) out_q  <= bus.wdata[OUT_W-1:0];
      if (wr_c && bus.addr == 2'd3) irq_en <= bus.wdata[IN_W-1:0];
      if (rd_c) bus.rdata <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed, table-driven bench for gpio_port.
module tb_gpio_port;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + 16;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_i;
  logic [8:0] gpio_o;
  logic       irq;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [31:0] d;

  gpio_port_if bus ();

  gpio_port #(.IN_W(8), .OUT_W(9), .DEB_CYCLES(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .gpio_i(gpio_i),
    .gpio_o(gpio_o),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [8:0]  exp_gpio_o;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] wd);
    bus.sel = 1'b1; bus.we = w; bus.addr = a; bus.wdata = wd;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    access(1'b0, a, 32'h0);
    v = bus.rdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //          we    addr  wdata          rdata          gpio_o   irq
    vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0,         9'h000, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0,         9'h000, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0,         9'h000, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0,         9'h000, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 32'hFFFF_F1A5, 32'h0,         9'h1A5, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 32'h0,         32'h0000_01A5, 9'h1A5, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 32'h1234_5678, 32'h0000_01A5, 9'h1A5, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0,         9'h1A5, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FF08, 32'h0,         9'h1A5, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0008, 9'h1A5, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 32'h0000_0E5A, 32'h0000_0008, 9'h05A, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 32'h0,         32'h0000_005A, 9'h05A, 1'b0};

    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
    gpio_i = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_gpio_o", 32'(gpio_o), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_gpio_o));
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Rising edge on bit 3: exact latency, EDGE capture, irq (IRQ_EN = 0x08)
    gpio_i = 8'h08;
    repeat (LAT - 1) tick();
    rd(2'd0, d); check("rise_in_early", d, 32'h0);
    rd(2'd0, d); check("rise_in", d, 32'h08);
    rd(2'd2, d); check("rise_edge", d, 32'h08);
    check("rise_irq", 32'(irq), 32'h1);

    // W1C clear; irq drops one cycle later
    access(1'b1, 2'd2, 32'hFFFF_FF08);
    check("clr_irq_lag", 32'(irq), 32'h1);
    tick();
    check("clr_irq", 32'(irq), 32'h0);
    rd(2'd2, d); check("clr_edge", d, 32'h0);

    // Falling edge sets nothing; then a new edge collides with a clear
    gpio_i = 8'h00;
    repeat (LAT + 2) tick();
    rd(2'd2, d); check("fall_edge", d, 32'h0);
    rd(2'd0, d); check("fall_in", d, 32'h0);
    gpio_i = 8'h08;
    repeat (LAT - 1) tick();
    access(1'b1, 2'd2, 32'h08);
    check("coll_irq_lag", 32'(irq), 32'h0);
    tick();
    check("coll_irq", 32'(irq), 32'h1);
    rd(2'd2, d); check("coll_edge", d, 32'h08);

`ifdef GPIO_DEBOUNCE_EN
    // 10-cycle glitch on bit 0 is rejected
    access(1'b1, 2'd2, 32'hFF);
    gpio_i = 8'h09;
    repeat (10) tick();
    gpio_i = 8'h08;
    repeat (LAT + 4) tick();
    rd(2'd0, d); check("glitch_in", d, 32'h08);
    rd(2'd2, d); check("glitch_edge", d, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);
`else
    // Without debounce the input appears after the synchroniser only
    gpio_i = 8'h00;
    do_reset();
    gpio_i = 8'h5A;
    tick();
    rd(2'd0, d); check("nodeb_in_early", d, 32'h0);
    rd(2'd0, d); check("nodeb_in", d, 32'h5A);
    rd(2'd2, d); check("nodeb_edge", d, 32'h5A);
`endif

    // Reset mid-count with a simultaneous write; pin held through reset
    gpio_i = 8'h00;
    do_reset();
    repeat (LAT + 2) tick();
    gpio_i = 8'h02;
    repeat (10) tick();
    rst = 1'b1;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'd1; bus.wdata = 32'h1FF;
    tick();
    rst = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0;
    check("rstpri_gpio_o", 32'(gpio_o), 32'h0);
    check("rstpri_rdata", bus.rdata, 32'h0);
    check("rstpri_irq", 32'(irq), 32'h0);
    repeat (LAT - 1) tick();
    rd(2'd2, d); check("rsthold_edge_early", d, 32'h0);
    rd(2'd2, d); check("rsthold_edge", d, 32'h02);
    rd(2'd0, d); check("rsthold_in", d, 32'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
